// File: rtl/edp_pkg.sv
// Shared encodings for the EDP multiply/divide sequencer: MQ shift codes,
// AD function codes packed as {cin,bool,sel}, AD mux selects and FSM states.
package edp_pkg;

  localparam logic [1:0] USR_LOAD = 2'b00;
  localparam logic [1:0] USR_SHL  = 2'b01;
  localparam logic [1:0] USR_SHR  = 2'b10;
  localparam logic [1:0] USR_HOLD = 2'b11;

  localparam logic [5:0] AD_APLUSB  = 6'b000110;
  localparam logic [5:0] AD_AMINUSB = 6'b101001;
  localparam logic [5:0] AD_A       = 6'b011111;

  localparam logic [1:0] ADA_AR  = 2'b00;
  localparam logic [1:0] ADB_BR  = 2'b10;
  localparam logic [1:0] MQM_SHR = 2'b10;
  localparam logic [1:0] MQM_IDLE = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP,
    S_FIXUP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/edp_step_ctr.sv
// Loadable down-counter for the sequencer iteration count; saturates at zero
// and flags zero / one so the FSM can pick its exit on the last step.
module edp_step_ctr #(
  parameter int STEPW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [STEPW-1:0] load_val_i,
  output logic [STEPW-1:0] cnt_o,
  output logic             zero_o,
  output logic             one_o
);

  logic [STEPW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - STEPW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == STEPW'(1));

endmodule

// File: rtl/edp_muldiv_seq.sv
// Microcode-started sequencer driving EDP controls for shift-add multiply and
// non-restoring divide; owns AD/AR/ARX/MQ controls while busy.
module edp_muldiv_seq
  import edp_pkg::*;
#(
  parameter int STEPW     = 6,
  parameter int DIV_FIXUP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [STEPW-1:0] stepCount,
  input  logic             abort,
  input  logic             mq35,
  input  logic             adCry0,
  output logic             busy,
  output logic             done,
  output logic             divOvf,
  output logic [3:0]       ADsel,
  output logic             ADbool,
  output logic             ADcin,
  output logic [1:0]       ADAsel,
  output logic [1:0]       ADBsel,
  output logic             ARload,
  output logic             ARXload,
  output logic [1:0]       MQsel,
  output logic [1:0]       MQMsel,
  output logic             MQMen,
  output logic [STEPW-1:0] stepCnt
);

  seq_state_t state_q, state_d;
  logic op_q, op_d;
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;
  logic cnt_clr, cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic [5:0] ad_fn;

  edp_step_ctr #(.STEPW(STEPW)) u_ctr (
    .clk        (clk),
    .rst        (reset),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (stepCount),
    .cnt_o      (stepCnt),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ad_fn    = AD_A;
    ARload   = 1'b0;
    ARXload  = 1'b0;
    MQsel    = USR_HOLD;
    MQMsel   = MQM_IDLE;
    MQMen    = 1'b0;

    // A kill leaves every control at its idle value for the abort cycle itself.
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
      ovf_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d  = S_SETUP;
            op_d     = op;
            neg_d    = 1'b0;
            ovf_d    = 1'b0;
            cnt_load = 1'b1;
          end
        end
        S_SETUP: begin
          busy    = 1'b1;
          state_d = cnt_zero ? S_DONE : S_STEP;
          if (op_q) begin
            ad_fn = AD_AMINUSB;
            if (adCry0) begin
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        S_STEP: begin
          busy    = 1'b1;
          cnt_dec = 1'b1;
          ARload  = 1'b1;
          if (op_q) begin
            ad_fn = neg_q ? AD_APLUSB : AD_AMINUSB;
            MQsel = USR_SHL;
            neg_d = ~adCry0;
          end else begin
            ad_fn   = mq35 ? AD_APLUSB : AD_A;
            ARXload = 1'b1;
            MQMen   = 1'b1;
            MQMsel  = MQM_SHR;
            MQsel   = USR_SHR;
          end
          if (cnt_one)
            state_d = (op_q && (DIV_FIXUP != 0) && neg_d) ? S_FIXUP : S_DONE;
        end
        S_FIXUP: begin
          busy    = 1'b1;
          ad_fn   = AD_APLUSB;
          ARload  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          busy    = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign {ADcin, ADbool, ADsel} = ad_fn;
  assign ADAsel = ADA_AR;
  assign ADBsel = ADB_BR;
  assign divOvf = ovf_q;

endmodule
